// File: rtl/morse_to_ascii.sv
// Morse key decoder: classifies key presses as dots or dashes from tick-counted
// durations, buffers up to five symbols, and emits the ITU-decoded ASCII
// character once the key has been idle for GAP_CHAR ticks.
//
// Optional feature: define MORSE_WORD_SPACE_EN to emit a space (32) once per
// word after GAP_WORD idle ticks counted from the gap that ended the word.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   key          Morse key, 1 = pressed (synchronized, debounced)
//   tick         one-cycle timebase enable; all durations are in ticks
//   ascii        decoded character, held until the next emission
//   ascii_valid  one-cycle pulse marking a new ascii value
//   sym_count    symbols buffered for the current character (0-5)
//   error        one-cycle pulse with ascii_valid for unknown/overlong patterns
module morse_to_ascii #(
  parameter int unsigned DOT_MAX  = 3,
  parameter int unsigned GAP_CHAR = 5,
  parameter int unsigned GAP_WORD = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key,
  input  logic       tick,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  output logic [2:0] sym_count,
  output logic       error
);

  localparam int unsigned PW = $clog2(DOT_MAX + 2);
  localparam int unsigned GW = $clog2(GAP_CHAR + 1);

  // The word gap is measured from the same origin as the character gap.
  if (GAP_WORD <= GAP_CHAR) begin : g_bad_gap_word
    $error("GAP_WORD must exceed GAP_CHAR");
  end

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] press_cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    pat;        // symbols, newest in bit 0; 1 = dash
  logic          ovf;
  logic          gap_done;
  logic          is_dash;
  logic [7:0]    dec_c;

  assign gap_done = (state == GAP) && (gap_cnt == GW'(GAP_CHAR));
  assign is_dash  = press_cnt > PW'(DOT_MAX);

  // ITU Morse lookup keyed by {length, pattern}; first symbol is the MSB.
  always_comb begin
    dec_c = 8'd63;
    case ({sym_count, pat})
      {3'd1, 5'b00000}: dec_c = 8'd69;  // E
      {3'd1, 5'b00001}: dec_c = 8'd84;  // T
      {3'd2, 5'b00000}: dec_c = 8'd73;  // I
      {3'd2, 5'b00001}: dec_c = 8'd65;  // A
      {3'd2, 5'b00010}: dec_c = 8'd78;  // N
      {3'd2, 5'b00011}: dec_c = 8'd77;  // M
      {3'd3, 5'b00000}: dec_c = 8'd83;  // S
      {3'd3, 5'b00001}: dec_c = 8'd85;  // U
      {3'd3, 5'b00010}: dec_c = 8'd82;  // R
      {3'd3, 5'b00011}: dec_c = 8'd87;  // W
      {3'd3, 5'b00100}: dec_c = 8'd68;  // D
      {3'd3, 5'b00101}: dec_c = 8'd75;  // K
      {3'd3, 5'b00110}: dec_c = 8'd71;  // G
      {3'd3, 5'b00111}: dec_c = 8'd79;  // O
      {3'd4, 5'b00000}: dec_c = 8'd72;  // H
      {3'd4, 5'b00001}: dec_c = 8'd86;  // V
      {3'd4, 5'b00010}: dec_c = 8'd70;  // F
      {3'd4, 5'b00100}: dec_c = 8'd76;  // L
      {3'd4, 5'b00110}: dec_c = 8'd80;  // P
      {3'd4, 5'b00111}: dec_c = 8'd74;  // J
      {3'd4, 5'b01000}: dec_c = 8'd66;  // B
      {3'd4, 5'b01001}: dec_c = 8'd88;  // X
      {3'd4, 5'b01010}: dec_c = 8'd67;  // C
      {3'd4, 5'b01011}: dec_c = 8'd89;  // Y
      {3'd4, 5'b01100}: dec_c = 8'd90;  // Z
      {3'd4, 5'b01101}: dec_c = 8'd81;  // Q
      {3'd5, 5'b00000}: dec_c = 8'd53;  // 5
      {3'd5, 5'b00001}: dec_c = 8'd52;  // 4
      {3'd5, 5'b00011}: dec_c = 8'd51;  // 3
      {3'd5, 5'b00111}: dec_c = 8'd50;  // 2
      {3'd5, 5'b01111}: dec_c = 8'd49;  // 1
      {3'd5, 5'b10000}: dec_c = 8'd54;  // 6
      {3'd5, 5'b11000}: dec_c = 8'd55;  // 7
      {3'd5, 5'b11100}: dec_c = 8'd56;  // 8
      {3'd5, 5'b11110}: dec_c = 8'd57;  // 9
      {3'd5, 5'b11111}: dec_c = 8'd48;  // 0
      default:          dec_c = 8'd63;
    endcase
    if (ovf) dec_c = 8'd63;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state; a press on the terminating cycle starts a fresh character.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (key) state_nx = PRESS;
      PRESS:   if (!key) state_nx = GAP;
      GAP: begin
        if (gap_done)  state_nx = key ? PRESS : IDLE;
        else if (key)  state_nx = PRESS;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MORSE_WORD_SPACE_EN
  localparam int unsigned WW = $clog2(GAP_WORD + 1);
  logic [WW-1:0] word_cnt;
  logic          word_armed;
  logic          word_emit;

  assign word_emit = (state == IDLE) && !key && word_armed &&
                     (word_cnt == WW'(GAP_WORD));
`endif

  // Counters, symbol buffer and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_cnt   <= '0;
      gap_cnt     <= '0;
      pat         <= '0;
      ovf         <= 1'b0;
      sym_count   <= 3'd0;
      ascii       <= 8'd0;
      ascii_valid <= 1'b0;
      error       <= 1'b0;
`ifdef MORSE_WORD_SPACE_EN
      word_cnt    <= '0;
      word_armed  <= 1'b0;
`endif
    end else begin
      ascii_valid <= 1'b0;
      error       <= 1'b0;
      case (state)
        IDLE: begin
          if (key) press_cnt <= PW'(tick);
        end
        PRESS: begin
          if (key) begin
            if (tick && press_cnt != PW'(DOT_MAX + 1))
              press_cnt <= press_cnt + PW'(1);
          end else begin
            gap_cnt <= '0;
            if (sym_count == 3'd5) begin
              ovf <= 1'b1;
            end else begin
              pat       <= {pat[3:0], is_dash};
              sym_count <= sym_count + 3'd1;
            end
          end
        end
        GAP: begin
          if (gap_done) begin
            ascii       <= dec_c;
            ascii_valid <= 1'b1;
            error       <= (dec_c == 8'd63);
            pat         <= '0;
            sym_count   <= 3'd0;
            ovf         <= 1'b0;
            gap_cnt     <= '0;
            if (key) press_cnt <= PW'(tick);
          end else if (key) begin
            press_cnt <= PW'(tick);
          end else if (tick) begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: ;
      endcase
`ifdef MORSE_WORD_SPACE_EN
      // Idle ticks since GAP entry; armed by a character emission, disarmed
      // by any press or by the space itself.
      if (state == PRESS && !key) begin
        word_cnt <= '0;
      end else if (state != PRESS && !key && tick &&
                   word_cnt != WW'(GAP_WORD)) begin
        word_cnt <= word_cnt + WW'(1);
      end
      if (gap_done) word_armed <= !key;
      else if (key || word_emit) word_armed <= 1'b0;
      if (word_emit) begin
        ascii       <= 8'd32;
        ascii_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_morse_to_ascii.sv
// Self-checking bench for morse_to_ascii (DOT_MAX=3, GAP_CHAR=5, GAP_WORD=10).
// Expected characters are queued as stimulus is driven; a monitor pops and
// compares each ascii_valid pulse.
module tb_morse_to_ascii;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key   = 1'b0;
  logic       tick  = 1'b1;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic [2:0] sym_count;
  logic       error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic       e;
  } exp_t;

  typedef struct {
    string      pat;
    logic [7:0] a;
    logic       e;
  } vec_t;

  exp_t q[$];
  vec_t vecs[10];

  morse_to_ascii #(.DOT_MAX(3), .GAP_CHAR(5), .GAP_WORD(10)) dut (
    .clock(clock), .reset(reset), .key(key), .tick(tick),
    .ascii(ascii), .ascii_valid(ascii_valid),
    .sym_count(sym_count), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled away from the rising edge.
  always @(negedge clock) begin
    if (!reset && ascii_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_emit: got ascii=%0d error=%0d expected none",
                 ascii, error);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("emit_ascii", int'(ascii), int'(e.a));
        chk("emit_error", int'(error), int'(e.e));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input int n);
    key = 1'b1;
    cyc(n);
  endtask

  task automatic idle(input int n);
    key = 1'b0;
    cyc(n);
  endtask

  task automatic push(input logic [7:0] a, input logic e);
    exp_t x;
    x.a = a;
    x.e = e;
    q.push_back(x);
  endtask

  // Dot = 2-tick press, dash = 6-tick press, 2-tick symbol gaps, then idle.
  task automatic send(input string s, input logic [7:0] a, input logic e);
    push(a, e);
    for (int i = 0; i < s.len(); i++) begin
      press((s[i] == 8'd45) ? 6 : 2);
      idle(2);
    end
    idle(6);
  endtask

  task automatic drain(input string name);
    chk(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{".-",     8'd65, 1'b0};
    vecs[1] = '{"-----",  8'd48, 1'b0};
    vecs[2] = '{".....",  8'd53, 1'b0};
    vecs[3] = '{"......", 8'd63, 1'b1};
    vecs[4] = '{"..--",   8'd63, 1'b1};
    vecs[5] = '{"--.-",   8'd81, 1'b0};
    vecs[6] = '{"----.",  8'd57, 1'b0};
    vecs[7] = '{".----",  8'd49, 1'b0};
    vecs[8] = '{"-.-.",   8'd67, 1'b0};
    vecs[9] = '{"...",    8'd83, 1'b0};

    // Reset state.
    cyc(2);
    chk("rst_ascii", int'(ascii), 0);
    chk("rst_valid", int'(ascii_valid), 0);
    chk("rst_sym", int'(sym_count), 0);
    chk("rst_error", int'(error), 0);
    reset = 1'b0;
    cyc(2);

    // Table of characters.
    foreach (vecs[i]) begin
      send(vecs[i].pat, vecs[i].a, vecs[i].e);
      drain({"vec_", vecs[i].pat});
    end

    // A with symbol count progression.
    push(8'd65, 1'b0);
    press(2); idle(2);
    chk("a_sym1", int'(sym_count), 1);
    press(6); idle(1);
    chk("a_sym2", int'(sym_count), 2);
    idle(7);
    chk("a_sym0", int'(sym_count), 0);
    drain("a_drain");

    // Overflow: count holds at 5 through the 6th press.
    push(8'd63, 1'b1);
    for (int i = 0; i < 5; i++) begin
      press(2); idle(2);
    end
    chk("ovf_sym5", int'(sym_count), 5);
    press(2);
    chk("ovf_sym5_press", int'(sym_count), 5);
    idle(1);
    chk("ovf_sym5_after", int'(sym_count), 5);
    idle(7);
    drain("ovf_drain");

    // Dot/dash boundary at DOT_MAX.
    push(8'd69, 1'b0); press(3); idle(8); drain("dot_max");
    push(8'd84, 1'b0); press(4); idle(8); drain("dot_max_plus1");

    // Press one cycle before the gap terminates continues the character.
    push(8'd65, 1'b0);
    press(2); idle(5); press(6); idle(8);
    drain("gap_minus1");

    // Press on the terminating cycle emits and starts a new character.
    push(8'd69, 1'b0); push(8'd84, 1'b0);
    press(2); idle(6); press(6); idle(8);
    drain("gap_term_press");

    // Tick held low: symbol buffers, nothing emits until ticks resume.
    tick = 1'b0;
    press(3); idle(20);
    chk("notick_sym", int'(sym_count), 1);
    chk("notick_none", q.size(), 0);
    push(8'd69, 1'b0);
    tick = 1'b1;
    idle(8);
    drain("notick_resume");

    // Reset mid-character discards it.
    press(2); idle(2); press(2); idle(2); press(2); idle(2);
    chk("mid_sym3", int'(sym_count), 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_ascii", int'(ascii), 0);
    chk("mid_rst_sym", int'(sym_count), 0);
    chk("mid_rst_valid", int'(ascii_valid), 0);
    chk("mid_rst_error", int'(error), 0);
    cyc(2);
    reset = 1'b0;
    idle(12);
    push(8'd84, 1'b0);
    press(6); idle(8);
    drain("post_rst_t");

    // Word space after a long idle.
    push(8'd69, 1'b0);
`ifdef MORSE_WORD_SPACE_EN
    push(8'd32, 1'b0);
`endif
    press(2); idle(25);
    drain("word_space");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
